idli_uart_m: RTL and testbench

IDLI_UART_M -- requirements
Module: idli_uart_m

---
 rtl/idli_uart_m.sv | 196 +++++++++++++++++++
 tb/tb_idli_uart_m.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/idli_uart_m.sv
// idli_uart_m: 8N1 UART with independent TX/RX state machines and an RX buffer.
// Define IDLI_UART_RX_FIFO_EN for a 4-entry RX FIFO; the default build uses a single holding register.
module idli_uart_m #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  input  logic [7:0] i_uart_tx_data,
  input  logic       i_uart_tx_vld,
  output logic       o_uart_tx_rdy,
  output logic [7:0] o_uart_rx_data,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx_rdy,
  output logic       o_uart_rx_err,
  input  logic       i_uart_err_clr,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_idx, w_tx_idx_nxt;
  logic [7:0]    r_tx_byte, w_tx_byte_nxt;
  logic          r_tx, w_tx_nxt;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_idx, w_rx_idx_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic          w_rx_fall, w_rx_push, w_rx_ferr;
  logic          w_pop, w_acc, w_ovf;
  logic          r_err;
  assign o_uart_tx     = r_tx;
  assign o_uart_tx_rdy = r_tx_state == TX_IDLE;
  assign o_uart_rx_err = r_err;
  assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
  assign w_pop         = o_uart_rx_vld & i_uart_rx_rdy;
  // TX next-state: the line value is computed for the next state so o_uart_tx stays a flop
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_byte_nxt  = r_tx_byte;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (i_uart_tx_vld) begin
          w_tx_state_nxt = TX_START;
          w_tx_byte_nxt  = i_uart_tx_data;
          w_tx_idx_nxt   = '0;
        end
      end
      TX_START: if (r_tx_cnt == LP_LAST) begin
        w_tx_state_nxt = TX_DATA;
        w_tx_cnt_nxt   = '0;
        w_tx_idx_nxt   = '0;
      end
      TX_DATA: if (r_tx_cnt == LP_LAST) begin
        w_tx_cnt_nxt   = '0;
        w_tx_idx_nxt   = r_tx_idx + 1'b1;
        w_tx_state_nxt = r_tx_idx == 3'd7 ? TX_STOP : TX_DATA;
      end
      TX_STOP: if (r_tx_cnt == LP_LAST) begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = '0;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    w_tx_nxt = w_tx_state_nxt == TX_START ? 1'b0 :
               w_tx_state_nxt == TX_DATA  ? w_tx_byte_nxt[w_tx_idx_nxt] : 1'b1;
  end
  // TX state and serial output registers
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_byte  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx       <= w_tx_nxt;
    end
  end
  // RX line synchroniser plus one delayed copy for fall detection; a fall needs the line seen high first
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end
  // RX next-state: mid-start check, then one sample per bit period
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (w_rx_fall) w_rx_state_nxt = RX_START;
      end
      RX_START: if (r_rx_cnt == LP_HALF) begin
        w_rx_cnt_nxt   = '0;
        w_rx_idx_nxt   = '0;
        w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == LP_LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_idx_nxt   = r_rx_idx + 1'b1;
        w_rx_state_nxt = r_rx_idx == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (r_rx_cnt == LP_LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = RX_IDLE;
        w_rx_push      = r_rx_s2;
        w_rx_ferr      = ~r_rx_s2;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end
  // RX state registers
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end
`ifdef IDLI_UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  assign w_acc          = w_rx_push & (r_cnt != 3'd4 | w_pop);
  assign w_ovf          = w_rx_push & r_cnt == 3'd4 & ~w_pop;
  assign o_uart_rx_data = r_fifo[r_rp];
  assign o_uart_rx_vld  = r_cnt != 3'd0;
  // RX FIFO; when full a push with a pop reuses the slot being read out this cycle
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      for (int k = 0; k < 4; k++) r_fifo[k] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc) r_fifo[r_wp] <= r_rx_shift;
      if (w_acc) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {2'b0, w_acc} - {2'b0, w_pop};
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_vld;
  assign w_acc          = w_rx_push & (~r_hold_vld | w_pop);
  assign w_ovf          = w_rx_push & r_hold_vld & ~w_pop;
  assign o_uart_rx_data = r_hold;
  assign o_uart_rx_vld  = r_hold_vld;
  // single-entry RX holding register
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      if (w_acc) r_hold <= r_rx_shift;
      r_hold_vld <= w_acc | (r_hold_vld & ~w_pop);
    end
  end
`endif
  // sticky error: a new framing or overflow event beats a simultaneous clear
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) r_err <= 1'b0;
    else r_err <= (w_rx_ferr | w_ovf) ? 1'b1 : i_uart_err_clr ? 1'b0 : r_err;
  end
endmodule

// File: tb/tb_idli_uart_m.sv
// tb_idli_uart_m: scoreboard bench for idli_uart_m with TX line decoder and RX output monitor.
module tb_idli_uart_m;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_vld = 1'b0;
  logic       tx_rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_rdy = 1'b1;
  logic       rx_err;
  logic       err_clr = 1'b0;
  logic       rx_line = 1'b1;
  logic       tx_line;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tm_cnt = 0;
  logic       tm_act = 1'b0;
  logic [7:0] tm_byte = '0;

  idli_uart_m #(.CLKS_PER_BIT(16)) dut (
    .i_top_gck(clk), .i_top_rst_n(rst_n),
    .i_uart_tx_data(tx_data), .i_uart_tx_vld(tx_vld), .o_uart_tx_rdy(tx_rdy),
    .o_uart_rx_data(rx_data), .o_uart_rx_vld(rx_vld), .i_uart_rx_rdy(rx_rdy),
    .o_uart_rx_err(rx_err), .i_uart_err_clr(err_clr),
    .i_uart_rx(rx_line), .o_uart_tx(tx_line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // RX monitor: every byte the core consumes must be the next expected one
  always @(negedge clk) begin
    if (rst_n && rx_vld && rx_rdy) begin
      if (rx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h expected none at %0t", rx_data, $time);
      end else chk("rx_byte", rx_data, rx_q.pop_front());
    end
  end

  // TX monitor: decodes the serial line mid-bit and compares against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) tm_act <= 1'b0;
    else if (!tm_act) begin
      if (!tx_line) begin
        tm_act  <= 1'b1;
        tm_cnt  <= 1;
        tm_byte <= '0;
      end
    end else begin
      tm_cnt <= tm_cnt + 1;
      if (tm_cnt == 8) chk("tx_start_bit", tx_line, 0);
      else if (tm_cnt % 16 == 8 && tm_cnt < 152) tm_byte <= {tx_line, tm_byte[7:1]};
      else if (tm_cnt == 152) begin
        chk("tx_stop_bit", tx_line, 1);
        tm_act <= 1'b0;
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got 0x%0h expected none at %0t", tm_byte, $time);
        end else chk("tx_byte", tm_byte, tx_q.pop_front());
      end
    end
  end

  task automatic tx_accept(input logic [7:0] b);
    int n = 0;
    while (!tx_rdy && n < 400) begin
      tick(1);
      n++;
    end
    tx_data = b;
    tx_vld  = 1'b1;
    tick(1);
    tx_vld  = 1'b0;
    tx_data = ~b;
    chk("tx_rdy_busy", tx_rdy, 0);
  endtask

  task automatic tx_send(input logic [7:0] b);
    int n = 0;
    tx_accept(b);
    tx_q.push_back(b);
    while (!tx_rdy && n < 400) begin
      tick(1);
      n++;
    end
    chk("tx_frame_len", n, 160);
  endtask

  task automatic rx_bit(input logic b);
    rx_line = b;
    tick(16);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    rx_line = 1'b1;
  endtask

  initial begin
    tick(3);
    chk("rst_tx", tx_line, 1);
    chk("rst_tx_rdy", tx_rdy, 1);
    chk("rst_rx_vld", rx_vld, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_err", rx_err, 0);
    rst_n = 1'b1;
    tick(4);
    tx_send(8'hA5);
    tx_send(8'h00);
    tx_send(8'hFF);
    rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    tick(4);
    chk("rx_3c_err", rx_err, 0);
    chk("rx_3c_vld_after", rx_vld, 0);
    rx_line = 1'b0;
    tick(4);
    rx_line = 1'b1;
    tick(40);
    chk("glitch_vld", rx_vld, 0);
    chk("glitch_err", rx_err, 0);
    rx_frame(8'h55, 1'b0);
    tick(4);
    chk("ferr_err", rx_err, 1);
    chk("ferr_vld", rx_vld, 0);
    tick(20);
    chk("ferr_sticky", rx_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ferr_clr", rx_err, 0);
    fork
      tx_send(8'h5A);
      begin
        rx_q.push_back(8'hC3);
        rx_frame(8'hC3, 1'b1);
      end
    join
    tick(4);
    chk("dual_err", rx_err, 0);
    rx_rdy = 1'b0;
`ifdef IDLI_UART_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) rx_q.push_back(8'(i));
`else
    rx_q.push_back(8'h01);
`endif
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
    tick(4);
    chk("ovf_err", rx_err, 1);
    chk("ovf_vld", rx_vld, 1);
    chk("ovf_hold_data", rx_data, 8'h01);
    rx_rdy = 1'b1;
    tick(8);
    chk("ovf_drained", rx_vld, 0);
    chk("ovf_rx_q_empty", rx_q.size(), 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovf_clr", rx_err, 0);
    tx_accept(8'hA5);
    tick(72);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_line, 1);
    chk("mid_rst_rdy", tx_rdy, 1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    tx_send(8'h3C);
    rx_q.push_back(8'h96);
    rx_frame(8'h96, 1'b1);
    tick(4);
    chk("final_tx_q_empty", tx_q.size(), 0);
    chk("final_rx_q_empty", rx_q.size(), 0);
    chk("final_err", rx_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
